pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register carrying an
// opcode / rd / branch-result / ALU-result bundle, with synchronous flush
// and a saturating back-pressure counter.
// Build option: define PIPE_SKID_EN for a two-entry stage (main + skid)
// with a registered in_ready; otherwise a single-entry stage whose
// in_ready follows out_ready combinationally.
module pipe_stage_reg #(
    parameter int OP_W   = 5,
    parameter int RD_W   = 9,
    parameter int BR_W   = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [RD_W-1:0]   RdOut,
    input  logic [BR_W-1:0]   BranchResult,
    input  logic [DATA_W-1:0] AluResult,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   OpCodeOut,
    output logic [RD_W-1:0]   RdOutOut,
    output logic [BR_W-1:0]   BranchResultOut,
    output logic [DATA_W-1:0] AluResultOut,
    output logic [CNT_W-1:0]  StallCnt
);

    logic accept;
    logic drain;
    logic load_main;
    logic [OP_W-1:0]   src_op;
    logic [RD_W-1:0]   src_rd;
    logic [BR_W-1:0]   src_br;
    logic [DATA_W-1:0] src_alu;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              load_skid;
    logic [OP_W-1:0]   skid_op;
    logic [RD_W-1:0]   skid_rd;
    logic [BR_W-1:0]   skid_br;
    logic [DATA_W-1:0] skid_alu;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign in_ready = !skid_valid;

    // main loads from skid when the skid entry moves up, else from the input
    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        src_op    = OpCode;
        src_rd    = RdOut;
        src_br    = BranchResult;
        src_alu   = AluResult;
        if (!flush) begin
            if (skid_valid) begin
                load_main = drain;
                src_op    = skid_op;
                src_rd    = skid_rd;
                src_br    = skid_br;
                src_alu   = skid_alu;
            end else if (accept) begin
                load_main = !out_valid || out_ready;
                load_skid = out_valid && !out_ready;
            end
        end
    end

    // occupancy of main and skid; skid is only ever full behind a full main
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain)
                skid_valid <= 1'b0;
        end else if (accept) begin
            if (!out_valid || out_ready)
                out_valid <= 1'b1;
            else
                skid_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // skid data captures only when main is stalled full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_op  <= '0;
            skid_rd  <= '0;
            skid_br  <= '0;
            skid_alu <= '0;
        end else if (load_skid) begin
            skid_op  <= OpCode;
            skid_rd  <= RdOut;
            skid_br  <= BranchResult;
            skid_alu <= AluResult;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // single entry: main only ever loads from the input
    always_comb begin
        load_main = accept && !flush;
        src_op    = OpCode;
        src_rd    = RdOut;
        src_br    = BranchResult;
        src_alu   = AluResult;
    end

    // main occupancy: flush beats accept beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_valid <= 1'b0;
        else if (flush)
            out_valid <= 1'b0;
        else if (accept)
            out_valid <= 1'b1;
        else if (drain)
            out_valid <= 1'b0;
    end
`endif

    // output bundle changes only on a load; flush leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OpCodeOut       <= '0;
            RdOutOut        <= '0;
            BranchResultOut <= '0;
            AluResultOut    <= '0;
        end else if (load_main) begin
            OpCodeOut       <= src_op;
            RdOutOut        <= src_rd;
            BranchResultOut <= src_br;
            AluResultOut    <= src_alu;
        end
    end

    // saturating count of stalled-output cycles, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCnt <= '0;
        else if (out_valid && !out_ready && (StallCnt != {CNT_W{1'b1}}))
            StallCnt <= StallCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a randomized run,
// all compared against a queue-based occupancy model of the stage.
module tb_pipe_stage_reg;

    localparam int BW = 5 + 9 + 7 + 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  OpCode = '0;
    logic [8:0]  RdOut = '0;
    logic [6:0]  BranchResult = '0;
    logic [31:0] AluResult = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  OpCodeOut;
    logic [8:0]  RdOutOut;
    logic [6:0]  BranchResultOut;
    logic [31:0] AluResultOut;
    logic [3:0]  StallCnt;

    int total = 0;
    int bad = 0;

    logic [BW-1:0] q[$];
    logic [BW-1:0] m_shown;
    int            m_cnt;

    pipe_stage_reg #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .OpCode(OpCode), .RdOut(RdOut), .BranchResult(BranchResult), .AluResult(AluResult),
        .out_valid(out_valid), .out_ready(out_ready),
        .OpCodeOut(OpCodeOut), .RdOutOut(RdOutOut),
        .BranchResultOut(BranchResultOut), .AluResultOut(AluResultOut),
        .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] dut_bundle();
        return {OpCodeOut, RdOutOut, BranchResultOut, AluResultOut};
    endfunction

    function automatic logic exp_ready();
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [BW-1:0] rand_bundle();
        logic [BW-1:0] b;
        b = {$urandom(), $urandom()};
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_shown = '0;
        m_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic [BW-1:0] b, input logic r, input logic f);
        in_valid = v;
        {OpCode, RdOut, BranchResult, AluResult} = b;
        out_ready = r;
        flush = f;
        #1;
    endtask

    // one clock edge; the model advances using the values presented before it
    task automatic tick();
        logic acc, drn, stall;
        logic [BW-1:0] cur;
        acc = in_valid && exp_ready();
        drn = (q.size() > 0) && out_ready;
        stall = (q.size() > 0) && !out_ready;
        cur = {OpCode, RdOut, BranchResult, AluResult};
        @(posedge clk);
        if (stall && m_cnt < 15) m_cnt++;
        if (flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        if (q.size() > 0) m_shown = q[0];
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || StallCnt !== 4'h0 || dut_bundle() !== '0) begin
            bad++;
            $display("FAIL reset: out_valid=%b in_ready=%b cnt=%h data=%h, want 0/1/0/0",
                     out_valid, in_ready, StallCnt, dut_bundle());
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, {5'h03, 9'h0, 7'h0, 32'h0000_1234}, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || OpCodeOut !== 5'h03 || AluResultOut !== 32'h1234) begin
            bad++;
            $display("FAIL single_out: valid=%b op=%h alu=%h, want 1/03/1234", out_valid, OpCodeOut, AluResultOut);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || OpCodeOut !== 5'h03 || AluResultOut !== 32'h1234) begin
            bad++;
            $display("FAIL single_hold: valid=%b op=%h alu=%h, want 0/03/1234", out_valid, OpCodeOut, AluResultOut);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, {21'h0, 32'(k)}, 1'b1, 1'b0);
            tick();
            total++;
            if (out_valid !== 1'b1 || AluResultOut !== 32'(k) || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream[%0d]: valid=%b alu=%h ready=%b, want 1/%h/1",
                         k, out_valid, AluResultOut, in_ready, k);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || StallCnt !== 4'h0) begin
            bad++;
            $display("FAIL stream_end: valid=%b cnt=%h, want 0/0", out_valid, StallCnt);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] a, b;
        a = {21'h0, 32'hAAAA_0001};
        b = {21'h0, 32'hBBBB_0002};
        do_reset();
        drive(1'b1, a, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        total++;
`ifdef PIPE_SKID_EN
        if (in_ready !== 1'b0 || dut_bundle() !== a || StallCnt !== 4'd3) begin
`else
        if (in_ready !== 1'b0 || dut_bundle() !== a || StallCnt !== 4'd3) begin
`endif
            bad++;
            $display("FAIL bp_hold: ready=%b data=%h cnt=%0d, want 0/%h/3", in_ready, dut_bundle(), StallCnt, a);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        total++;
`ifdef PIPE_SKID_EN
        if (out_valid !== 1'b1 || dut_bundle() !== b) begin
            bad++;
            $display("FAIL bp_second: valid=%b data=%h, want 1/%h", out_valid, dut_bundle(), b);
        end
`else
        if (out_valid !== 1'b0 || dut_bundle() !== a) begin
            bad++;
            $display("FAIL bp_second: valid=%b data=%h, want 0/%h", out_valid, dut_bundle(), a);
        end
`endif
        tick();
        total++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            bad++;
            $display("FAIL bp_empty: valid=%b model_depth=%0d, want 0/0", out_valid, q.size());
        end
    endtask

    task automatic test_flush();
        logic [BW-1:0] a, b, c;
        a = rand_bundle();
        b = rand_bundle();
        c = rand_bundle();
        do_reset();
        drive(1'b1, a, 1'b0, 1'b0);
        tick();
        drive(1'b1, b, 1'b0, 1'b0);
        tick();
        drive(1'b1, c, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_bundle() !== a) begin
            bad++;
            $display("FAIL flush: valid=%b ready=%b data=%h, want 0/1/%h", out_valid, in_ready, dut_bundle(), a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || dut_bundle() !== a) begin
                bad++;
                $display("FAIL flush_after[%0d]: valid=%b data=%h, want 0/%h", i, out_valid, dut_bundle(), a);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b1, rand_bundle(), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (StallCnt !== 4'hF || m_cnt != 15) begin
            bad++;
            $display("FAIL saturate: cnt=%h, want f", StallCnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (StallCnt !== 4'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: cnt=%h valid=%b, want 0/0", StallCnt, out_valid);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_bundle(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            total++;
            if (in_ready !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got=%b want=%b", i, in_ready, exp_ready());
            end
            tick();
            total++;
            if (out_valid !== (q.size() > 0) || dut_bundle() !== m_shown || StallCnt !== 4'(m_cnt)) begin
                bad++;
                errs++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h cnt=%0d, want %b/%h/%0d",
                         i, out_valid, dut_bundle(), StallCnt, q.size() > 0, m_shown, m_cnt);
            end
            if (errs > 10) break;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
